tx_fir_mac: RTL and testbench
=============================

// Module: tx_fir_mac
// PURPOSE
//  Time-multiplexed transmit FIR stage downstream of imm_product. It shares one
//  Q3.13 signed multiplier across TAPS coefficients and accumulates the full-precision
//  products. It rounds, saturates and emits one Q3.13 filtered sample per input sample.
//  It sits between the symbol mapper and the DAC interface, with valid/ready on both sides.
// PARAMETERS
//  TAPS   8   number of filter taps (power of 2, 2..32)
//  DW     16  sample/coef/output width, signed two's complement
//  FRAC   13  fractional bits (Q3.13: 16'h2000 = 1.0)
//  ACC_W  35  accumulator width, = 2*DW + log2(TAPS)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block can accept a sample
//  in_data    in   DW     input sample, Q3.13
//  coef_we    in   1      coefficient write strobe
//  coef_addr  in   log2(TAPS)  coefficient index
//  coef_data  in   DW     coefficient, Q3.13
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts out_data
//  out_data   out  DW     filtered sample, Q3.13
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: state=IDLE, in_ready=0 during rst and 1 on the first cycle after,
//    out_valid=0, out_data=0, accumulator=0, delay line x[0..TAPS-1]=0, coefs c[]=0.
//  - States: IDLE -> MAC -> OUT -> IDLE.
//  - IDLE: in_ready=1.
//    - On in_valid&in_ready: x[k]<=x[k-1] for k>0; x[0]<=in_data; acc<=0; k<=0; go MAC.
//    - Without in_valid: stay in IDLE.
//  - MAC: in_ready=0.
//    - Each cycle: acc <= acc + sext(x[k]*c[k]), using the full 2*DW-bit signed product.
//    - k increments each cycle. After k=TAPS-1 is summed, go OUT. MAC lasts exactly TAPS cycles.
//  - OUT:
//    - out_data = sat_DW((acc + 2^(FRAC-1)) >>> FRAC): round half up, arithmetic shift.
//    - Saturation clamps to 16'h7FFF / 16'h8000.
//    - out_valid=1; out_data is registered on OUT entry and held stable while out_valid=1.
//    - On out_valid&out_ready: out_valid<=0 and go IDLE.
//    - Without out_ready: hold indefinitely (backpressure).
//  - Latency: out_valid rises TAPS+1 clocks after the accepting edge.
//    Peak throughput is one sample per TAPS+2 clocks.
//  - Coefficient writes: c[coef_addr]<=coef_data only when state=IDLE and no sample is
//    accepted in that cycle. Writes in any other cycle are silently dropped.
//  - The accumulator never overflows: ACC_W covers TAPS full-scale products.
//  - rst asserted in any state: all reset values apply on the next edge.
//    An in-flight result is discarded and coefficients are cleared.
//  - out_ready is ignored while out_valid=0. in_valid is ignored while in_ready=0;
//    the sample is not consumed.
// TESTING
//  1. Identity: c[0]=16'h2000, rest 0; feed 16'h5555 -> out_data=16'h5555 after exactly 9 clks.
//  2. Rounding: c[0]=16'h0001, sample 16'h1000 -> 16'h0001.
//     Sample 16'hF000 -> 16'h0000.
//  3. Saturation: all c=16'h2000; feed eight 16'h7FFF -> last out=16'h7FFF.
//     Eight 16'h8000 -> last out=16'h8000.
//  4. Delay line: c[3]=16'h2000 only; feed 1,2,3,4,5 (x 16'h2000) -> outputs 0,0,0,16'h2000,16'h4000.
//  5. Backpressure: hold out_ready=0 for 20 clks -> out_valid and out_data stable,
//     in_ready=0 throughout.
//     Coef write during MAC is ignored: the next sample's result is unchanged.
//  6. Reset mid-MAC: rst at MAC cycle 4 -> next cycle out_valid=0 and in_ready=1
//     once rst drops. A following sample yields 0 (coefs cleared).

Source files
------------

// File: rtl/tx_fir_mac.sv
// -----------------------------------------------------------------------------
// tx_fir_mac
//
// Time-multiplexed transmit FIR stage. It shares one signed DW x DW multiplier
// across TAPS coefficients and accumulates the full-precision products. Each
// accepted input sample produces exactly one output sample. The output is
// rounded half up, shifted arithmetically by FRAC and saturated to DW bits.
//
// Operating sequence: IDLE -> MAC (TAPS cycles) -> OUT -> IDLE.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous, active-high reset
//   in_valid   in   1     in_data is valid
//   in_ready   out  1     block can accept a sample (IDLE and not in reset)
//   in_data    in   DW    input sample, signed Q3.13
//   coef_we    in   1     coefficient write strobe (honoured only in idle cycles
//                         that accept no sample)
//   coef_addr  in   KW    coefficient index
//   coef_data  in   DW    coefficient, signed Q3.13
//   out_valid  out  1     out_data is valid
//   out_ready  in   1     downstream accepts out_data
//   out_data   out  DW    filtered sample, signed Q3.13
//   dbg_state  out  2     current FSM state (IDLE=0, MAC=1, OUT=2)
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A producer holds valid and data stable until
// that transfer. Here, in_ready does not depend on in_valid. out_valid and
// out_data are registered and are held stable while out_ready is low.
// -----------------------------------------------------------------------------
module tx_fir_mac #(
  parameter int TAPS  = 8,
  parameter int DW    = 16,
  parameter int FRAC  = 13,
  parameter int ACC_W = 2 * DW + $clog2(TAPS),
  parameter int KW    = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          coef_we,
  input  logic [KW-1:0] coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [KW-1:0]           K_LAST = KW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_C  = ACC_W'(2 ** (FRAC - 1));
  // Saturation bounds sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                   state_q, state_d;
  logic signed [DW-1:0]     x_q [TAPS];
  logic signed [DW-1:0]     c_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [KW-1:0]            k_q;
  logic                     out_valid_q;
  logic [DW-1:0]            out_data_q;

  logic                     accept;
  logic                     coef_wr_en;
  logic                     mac_last;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_shr;
  logic [DW-1:0]            sat_val;

  // ---------------------------------------------------------------------------
  // Datapath: one shared multiplier, addressed by the tap counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    prod     = x_q[k_q] * c_q[k_q];
    prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
    // The result is rounded and saturated from the final sum, so out_data can
    // be loaded on the same edge that leaves MAC.
    acc_rnd  = acc_sum + RND_C;
    acc_shr  = acc_rnd >>> FRAC;
    if (acc_shr > SAT_MAX) begin
      sat_val = {1'b0, {(DW-1){1'b1}}};
    end else if (acc_shr < SAT_MIN) begin
      sat_val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_val = acc_shr[DW-1:0];
    end
  end

  assign mac_last = (k_q == K_LAST);

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    coef_wr_en = 1'b0;
    // Held low during reset, whatever the state register holds.
    in_ready   = (state_q == IDLE) && !rst;
    case (state_q)
      IDLE: begin
        accept     = in_valid && in_ready;
        coef_wr_en = coef_we && !accept;
        if (accept) state_d = MAC;
      end
      MAC: begin
        if (mac_last) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) begin
          x_q[i] <= x_q[i-1];
        end
        x_q[0] <= in_data;
        acc_q  <= '0;
        k_q    <= '0;
      end

      if (coef_wr_en) begin
        c_q[coef_addr] <= coef_data;
      end

      if (state_q == MAC) begin
        acc_q <= acc_sum;
        k_q   <= k_q + KW'(1);
        if (mac_last) begin
          out_valid_q <= 1'b1;
          out_data_q  <= sat_val;
        end
      end

      if ((state_q == OUT) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_fir_mac.sv
// -----------------------------------------------------------------------------
// tb_tx_fir_mac
//
// Directed bench for tx_fir_mac. It uses hand-computed expected values, which
// pass through an expected queue to a single checking task.
// -----------------------------------------------------------------------------
module tb_tx_fir_mac;

  localparam int TAPS = 8;
  localparam int DW   = 16;
  localparam int KW   = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          coef_we;
  logic [KW-1:0] coef_addr;
  logic [DW-1:0] coef_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  tx_fir_mac #(.TAPS(TAPS), .DW(DW), .FRAC(13)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking task
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. All input changes and samples happen 1 time unit after a
  // rising edge.
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic write_coef(input logic [KW-1:0] a, input logic [DW-1:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic send(input logic [DW-1:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat counts clock edges from the accepting edge (inclusive) to the edge
  // that raises out_valid.
  task automatic collect(output logic [DW-1:0] r, output int lat);
    int n;
    n   = 0;
    lat = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      lat++;
      n++;
    end
    if (!out_valid) check("collect_timeout", 32'(out_valid), 32'd1);
    r         = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_sample(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] e);
    logic [DW-1:0] r;
    int lat;
    exp_q.push_back(e);
    send(d);
    collect(r, lat);
    check(tag, 32'(r), 32'(exp_q.pop_front()));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dl_in  [5];
  logic [DW-1:0] dl_exp [5];
  logic [DW-1:0] sat_exp[8];

  initial begin
    logic [DW-1:0] r;
    int lat;
    logic moved;

    dl_in   = '{16'h2000, 16'h4000, 16'h6000, 16'h8000, 16'hA000};
    dl_exp  = '{16'h0000, 16'h0000, 16'h0000, 16'h2000, 16'h4000};
    // Sum after j new 16'h8000 samples replace 16'h7FFF ones:
    // 8*32767 - j*65535 -> 196601, 131066, 65531, -4, ...
    sat_exp = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFC,
                16'h8000, 16'h8000, 16'h8000, 16'h8000};

    // Reset values
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1. Identity with latency
    write_coef(3'd0, 16'h2000);
    exp_q.push_back(16'h5555);
    send(16'h5555);
    collect(r, lat);
    check("identity", 32'(r), 32'(exp_q.pop_front()));
    check("latency", 32'(lat), 32'd9);
    check("idle_after_out", 32'(dbg_state), 32'd0);

    // 2. Rounding
    do_reset();
    write_coef(3'd0, 16'h0001);
    run_sample("round_up", 16'h1000, 16'h0001);
    run_sample("round_neg", 16'hF000, 16'h0000);

    // 3. Saturation
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(KW'(i), 16'h2000);
    for (int i = 0; i < TAPS; i++) run_sample("sat_pos", 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) run_sample("sat_neg", 16'h8000, sat_exp[i]);

    // 4. Delay line
    do_reset();
    write_coef(3'd3, 16'h2000);
    for (int i = 0; i < 5; i++) run_sample("delay_line", dl_in[i], dl_exp[i]);

    // 5. Backpressure. A competing sample and a coef write are offered during OUT.
    do_reset();
    write_coef(3'd0, 16'h2000);
    send(16'h1234);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("bp_out_valid_rise", 32'(out_valid), 32'd1);
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h4000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h1234);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    collect(r, lat);
    check("bp_result", 32'(r), 32'h1234);
    // 16'h7777 was not consumed and c[0] is unchanged: x = {0x0100, 0x1234, ...}
    run_sample("bp_no_consume", 16'h0100, 16'h0100);

    // Coef write during MAC is dropped.
    exp_q.push_back(16'h0200);
    send(16'h0200);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h4000;
    repeat (3) @(posedge clk);
    #1;
    coef_we = 1'b0;
    collect(r, lat);
    check("mac_write_cur", 32'(r), 32'(exp_q.pop_front()));
    run_sample("mac_write_next", 16'h0300, 16'h0300);

    // 6. Reset mid-MAC
    do_reset();
    write_coef(3'd0, 16'h2000);
    send(16'h1111);
    repeat (4) @(posedge clk);
    #1;
    check("mid_mac_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mac_out_valid", 32'(out_valid), 32'd0);
    check("rst_mac_state", 32'(dbg_state), 32'd0);
    check("rst_mac_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mac_in_ready_high", 32'(in_ready), 32'd1);
    moved = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) moved = 1'b1;
    end
    check("rst_mac_discarded", 32'(moved), 32'd0);
    run_sample("rst_coefs_cleared", 16'h1111, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

endmodule
